// File: rtl/alu_ctrl_muldiv_pkg.sv
// Shared constants for the EX-stage ALU control decoder and mul/div sequencer.
package alu_pkg;

    // ALU control codes
    localparam logic [3:0] ALU_ADD     = 4'd0;
    localparam logic [3:0] ALU_SUB     = 4'd1;
    localparam logic [3:0] ALU_SLL     = 4'd2;
    localparam logic [3:0] ALU_NOR     = 4'd3;
    localparam logic [3:0] ALU_AND     = 4'd4;
    localparam logic [3:0] ALU_SLT     = 4'd5;
    localparam logic [3:0] ALU_OR      = 4'd6;
    localparam logic [3:0] ALU_SRL     = 4'd7;
    localparam logic [3:0] ALU_PASS_HI = 4'd8;
    localparam logic [3:0] ALU_PASS_LO = 4'd9;
    localparam logic [3:0] ALU_NOP     = 4'd15;

    // alu_op encodings from main control
    localparam logic [2:0] OP_ADD   = 3'b000;
    localparam logic [2:0] OP_SUB   = 3'b001;
    localparam logic [2:0] OP_OR    = 3'b010;
    localparam logic [2:0] OP_AND   = 3'b011;
    localparam logic [2:0] OP_RTYPE = 3'b100;

    // R-type funct field
    localparam logic [5:0] FN_SLL   = 6'b000000;
    localparam logic [5:0] FN_SRL   = 6'b000010;
    localparam logic [5:0] FN_MFHI  = 6'b010000;
    localparam logic [5:0] FN_MTHI  = 6'b010001;
    localparam logic [5:0] FN_MFLO  = 6'b010010;
    localparam logic [5:0] FN_MTLO  = 6'b010011;
    localparam logic [5:0] FN_MULT  = 6'b011000;
    localparam logic [5:0] FN_MULTU = 6'b011001;
    localparam logic [5:0] FN_DIV   = 6'b011010;
    localparam logic [5:0] FN_DIVU  = 6'b011011;
    localparam logic [5:0] FN_ADD   = 6'b100000;
    localparam logic [5:0] FN_SUB   = 6'b100010;
    localparam logic [5:0] FN_AND   = 6'b100100;
    localparam logic [5:0] FN_OR    = 6'b100101;
    localparam logic [5:0] FN_NOR   = 6'b100111;
    localparam logic [5:0] FN_SLT   = 6'b101010;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2,
        ST_DONE = 2'd3
    } md_state_e;

    // MULT/MULTU/DIV/DIVU all live in 0110xx
    function automatic logic is_muldiv(input logic [5:0] fn);
        return fn[5:2] == 4'b0110;
    endfunction

endpackage

// File: rtl/alu_ctrl_muldiv_if.sv
// EX-stage bus between main control / forwarding and the ALU control block.
interface alu_ctrl_muldiv_if #(
    parameter int WIDTH  = 32,
    parameter int CTRL_W = 4
);
    logic              valid;
    logic              flush;
    logic [2:0]        alu_op;
    logic [5:0]        funct;
    logic [WIDTH-1:0]  rs_val;
    logic [WIDTH-1:0]  rt_val;
    logic [CTRL_W-1:0] alu_control;
    logic              illegal;
    logic              stall;
    logic [WIDTH-1:0]  hi;
    logic [WIDTH-1:0]  lo;

    modport master (
        output valid, flush, alu_op, funct, rs_val, rt_val,
        input  alu_control, illegal, stall, hi, lo
    );

    modport slave (
        input  valid, flush, alu_op, funct, rs_val, rt_val,
        output alu_control, illegal, stall, hi, lo
    );
endinterface

// File: rtl/alu_ctrl_muldiv_iter.sv
// Iterative multiply/divide datapath: one shift-add or restoring-subtract
// step per cycle on operand magnitudes, sign fix-up applied on the outputs.
module muldiv_iter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             is_div,
    input  logic             is_signed,
    input  logic             abort,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             done,
    output logic [WIDTH-1:0] hi_out,
    output logic [WIDTH-1:0] lo_out
);
    localparam int CW = $clog2(WIDTH) + 1;

    logic             run, div_q, div0_q, neg_q, rneg_q;
    logic [WIDTH-1:0] acc, sq, mb, a_raw;
    logic [CW-1:0]    cnt;

    logic             a_neg, b_neg;
    logic [WIDTH-1:0] a_mag, b_mag;
    logic [WIDTH:0]   mul_sum, shifted;
    logic             sub_ok;
    logic [2*WIDTH-1:0] prod, prod_fix;
    logic [WIDTH-1:0] quo, rem;

    // Operand magnitudes and one-step arithmetic
    always_comb begin
        a_neg   = is_signed & a[WIDTH-1];
        b_neg   = is_signed & b[WIDTH-1];
        a_mag   = a_neg ? -a : a;
        b_mag   = b_neg ? -b : b;
        mul_sum = {1'b0, acc} + {1'b0, (sq[0] ? mb : '0)};
        shifted = {acc, sq[WIDTH-1]};
        sub_ok  = shifted >= {1'b0, mb};
    end

    // Load on start, then iterate WIDTH steps; abort drops the run flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run <= 1'b0; div_q <= 1'b0; div0_q <= 1'b0; neg_q <= 1'b0; rneg_q <= 1'b0;
            acc <= '0; sq <= '0; mb <= '0; a_raw <= '0; cnt <= '0;
        end else if (abort) begin
            run <= 1'b0;
        end else if (start) begin
            run    <= 1'b1;
            cnt    <= '0;
            acc    <= '0;
            sq     <= a_mag;
            mb     <= b_mag;
            a_raw  <= a;
            div_q  <= is_div;
            div0_q <= (b == '0);
            neg_q  <= a_neg ^ b_neg;
            rneg_q <= a_neg;
        end else if (run) begin
            if (div_q) begin
                acc <= sub_ok ? (shifted[WIDTH-1:0] - mb) : shifted[WIDTH-1:0];
                sq  <= {sq[WIDTH-2:0], sub_ok};
            end else begin
                acc <= mul_sum[WIDTH:1];
                sq  <= {mul_sum[0], sq[WIDTH-1:1]};
            end
            cnt <= cnt + 1'b1;
            if (cnt == CW'(WIDTH - 1))
                run <= 1'b0;
        end
    end

    assign done = run & (cnt == CW'(WIDTH - 1));

    // Sign fix-up; divide-by-zero returns all-ones quotient and the raw dividend
    always_comb begin
        prod     = {acc, sq};
        prod_fix = neg_q ? -prod : prod;
        quo      = neg_q ? -sq : sq;
        rem      = rneg_q ? -acc : acc;
        if (div_q) begin
            hi_out = div0_q ? a_raw : rem;
            lo_out = div0_q ? '1 : quo;
        end else begin
            hi_out = prod_fix[2*WIDTH-1:WIDTH];
            lo_out = prod_fix[WIDTH-1:0];
        end
    end
endmodule

// File: rtl/alu_ctrl_muldiv.sv
// EX-stage ALU control decoder with HI/LO registers and mul/div sequencer.
module alu_ctrl_muldiv
    import alu_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int CTRL_W = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    alu_ctrl_muldiv_if.slave   bus
);
    md_state_e        state, state_nxt;
    logic [3:0]       code;
    logic             fn_ok, is_r, accept, it_done;
    logic [WIDTH-1:0] hi_q, lo_q, hi_res, lo_res;

    // alu_op / funct decode, independent of the sequencer state
    always_comb begin
        code  = ALU_NOP;
        fn_ok = 1'b1;
        case (bus.alu_op)
            OP_ADD:   code = ALU_ADD;
            OP_SUB:   code = ALU_SUB;
            OP_AND:   code = ALU_AND;
            OP_OR:    code = ALU_OR;
            OP_RTYPE: begin
                case (bus.funct)
                    FN_ADD:  code = ALU_ADD;
                    FN_SUB:  code = ALU_SUB;
                    FN_SLL:  code = ALU_SLL;
                    FN_SRL:  code = ALU_SRL;
                    FN_NOR:  code = ALU_NOR;
                    FN_AND:  code = ALU_AND;
                    FN_OR:   code = ALU_OR;
                    FN_SLT:  code = ALU_SLT;
                    FN_MFHI: code = ALU_PASS_HI;
                    FN_MFLO: code = ALU_PASS_LO;
                    FN_MTHI, FN_MTLO, FN_MULT, FN_MULTU, FN_DIV, FN_DIVU: code = ALU_NOP;
                    default: fn_ok = 1'b0;
                endcase
            end
            default:  code = ALU_NOP;
        endcase
    end

    assign is_r            = bus.alu_op == OP_RTYPE;
    assign bus.alu_control = CTRL_W'(code);
    assign bus.illegal     = bus.valid & is_r & ~fn_ok;

    assign accept    = (state == ST_IDLE) & bus.valid & is_r & is_muldiv(bus.funct) & ~bus.flush;
    assign bus.stall = (state == ST_MUL) | (state == ST_DIV) | accept;

    // Sequencer state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    // Next state; flush wins over accept and commit
    always_comb begin
        state_nxt = state;
        if (bus.flush) begin
            state_nxt = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE: if (accept) state_nxt = bus.funct[1] ? ST_DIV : ST_MUL;
                ST_MUL,
                ST_DIV:  if (it_done) state_nxt = ST_DONE;
                default: state_nxt = ST_IDLE;
            endcase
        end
    end

    muldiv_iter #(.WIDTH(WIDTH)) u_iter (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (accept),
        .is_div    (bus.funct[1]),
        .is_signed (~bus.funct[0]),
        .abort     (bus.flush),
        .a         (bus.rs_val),
        .b         (bus.rt_val),
        .done      (it_done),
        .hi_out    (hi_res),
        .lo_out    (lo_res)
    );

    // HI/LO: commit on leaving DONE, MTHI/MTLO only while idle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hi_q <= '0;
            lo_q <= '0;
        end else if (!bus.flush) begin
            if (state == ST_DONE) begin
                hi_q <= hi_res;
                lo_q <= lo_res;
            end else if (state == ST_IDLE && bus.valid && is_r) begin
                if (bus.funct == FN_MTHI) hi_q <= bus.rs_val;
                if (bus.funct == FN_MTLO) lo_q <= bus.rs_val;
            end
        end
    end

    assign bus.hi = hi_q;
    assign bus.lo = lo_q;
endmodule

// File: tb/tb_alu_ctrl_muldiv.sv
// Directed bench: decode table sweep plus hand-written mul/div sequences.
module tb_alu_ctrl_muldiv;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_cmp = 0;
    int   n_bad = 0;

    alu_ctrl_muldiv_if #(.WIDTH(32), .CTRL_W(4)) bus ();

    alu_ctrl_muldiv #(.WIDTH(32), .CTRL_W(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0] op;
        logic [5:0] fn;
        logic       vld;
        logic [3:0] code;
        logic       ill;
    } dec_vec_t;

    dec_vec_t tbl[20];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Issue one muldiv, count stall cycles, then check the committed HI/LO
    task automatic run_md(input string nm, input logic [5:0] fn, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] ehi, input logic [31:0] elo);
        int n;
        @(negedge clk);
        bus.valid = 1'b1; bus.alu_op = 3'b100; bus.funct = fn; bus.rs_val = a; bus.rt_val = b;
        #1;
        n = 0;
        while (bus.stall && n < 100) begin
            n++;
            @(posedge clk); #1;
        end
        bus.valid = 1'b0;
        chk({nm, " stall cycles"}, 64'(n), 64'd33);
        @(posedge clk); #1;
        chk({nm, " hi"}, 64'(bus.hi), 64'(ehi));
        chk({nm, " lo"}, 64'(bus.lo), 64'(elo));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        tbl[0]  = '{3'b100, 6'b100000, 1'b1, 4'd0,  1'b0};
        tbl[1]  = '{3'b100, 6'b100010, 1'b1, 4'd1,  1'b0};
        tbl[2]  = '{3'b100, 6'b000000, 1'b1, 4'd2,  1'b0};
        tbl[3]  = '{3'b100, 6'b100111, 1'b1, 4'd3,  1'b0};
        tbl[4]  = '{3'b100, 6'b100100, 1'b1, 4'd4,  1'b0};
        tbl[5]  = '{3'b100, 6'b101010, 1'b1, 4'd5,  1'b0};
        tbl[6]  = '{3'b100, 6'b100101, 1'b1, 4'd6,  1'b0};
        tbl[7]  = '{3'b100, 6'b000010, 1'b1, 4'd7,  1'b0};
        tbl[8]  = '{3'b100, 6'b010000, 1'b1, 4'd8,  1'b0};
        tbl[9]  = '{3'b100, 6'b010010, 1'b1, 4'd9,  1'b0};
        tbl[10] = '{3'b100, 6'b010001, 1'b0, 4'd15, 1'b0};
        tbl[11] = '{3'b100, 6'b011000, 1'b0, 4'd15, 1'b0};
        tbl[12] = '{3'b100, 6'b011011, 1'b0, 4'd15, 1'b0};
        tbl[13] = '{3'b100, 6'b111111, 1'b1, 4'd15, 1'b1};
        tbl[14] = '{3'b100, 6'b111111, 1'b0, 4'd15, 1'b0};
        tbl[15] = '{3'b000, 6'b111111, 1'b1, 4'd0,  1'b0};
        tbl[16] = '{3'b001, 6'b000000, 1'b1, 4'd1,  1'b0};
        tbl[17] = '{3'b011, 6'b000000, 1'b1, 4'd4,  1'b0};
        tbl[18] = '{3'b010, 6'b000000, 1'b1, 4'd6,  1'b0};
        tbl[19] = '{3'b110, 6'b100000, 1'b1, 4'd15, 1'b0};

        bus.valid = 1'b0; bus.flush = 1'b0; bus.alu_op = 3'b000; bus.funct = 6'b0;
        bus.rs_val = '0; bus.rt_val = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset hi", 64'(bus.hi), 64'd0);
        chk("reset lo", 64'(bus.lo), 64'd0);
        chk("reset stall", 64'(bus.stall), 64'd0);
        @(negedge clk); rst_n = 1'b1;

        // Decode sweep
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            bus.alu_op = tbl[i].op; bus.funct = tbl[i].fn; bus.valid = tbl[i].vld;
            #1;
            chk($sformatf("decode[%0d] code", i), 64'(bus.alu_control), 64'(tbl[i].code));
            chk($sformatf("decode[%0d] illegal", i), 64'(bus.illegal), 64'(tbl[i].ill));
        end
        @(negedge clk); bus.valid = 1'b0;

        run_md("MULT -3*7",     6'b011000, 32'hFFFFFFFD, 32'd7,        32'hFFFFFFFF, 32'hFFFFFFEB);
        run_md("MULTU ffff*2",  6'b011001, 32'hFFFFFFFF, 32'd2,        32'h00000001, 32'hFFFFFFFE);
        bus.funct = 6'b010000; bus.valid = 1'b1; #1;
        chk("MFHI after MULTU code", 64'(bus.alu_control), 64'd8);
        bus.valid = 1'b0;
        run_md("DIV -7/2",      6'b011010, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD);
        run_md("DIV min/-1",    6'b011010, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000);
        run_md("DIVU 100/7",    6'b011011, 32'd100,      32'd7,        32'd2,        32'd14);
        run_md("DIVU 5/0",      6'b011011, 32'd5,        32'd0,        32'd5,        32'hFFFFFFFF);

        // Flush after 10 multiply steps: HI/LO keep the DIVU 5/0 result
        @(negedge clk);
        bus.valid = 1'b1; bus.alu_op = 3'b100; bus.funct = 6'b011000;
        bus.rs_val = 32'd3; bus.rt_val = 32'd5;
        @(posedge clk);
        repeat (10) @(posedge clk);
        #1;
        chk("stall mid-MULT", 64'(bus.stall), 64'd1);
        bus.flush = 1'b1;
        @(posedge clk); #1;
        chk("flush stall", 64'(bus.stall), 64'd0);
        bus.flush = 1'b0; bus.valid = 1'b0;
        @(posedge clk); #1;
        chk("flush hi hold", 64'(bus.hi), 64'd5);
        chk("flush lo hold", 64'(bus.lo), 64'hFFFFFFFF);

        // MTLO after flush
        @(negedge clk);
        bus.valid = 1'b1; bus.funct = 6'b010011; bus.rs_val = 32'h1234;
        #1;
        chk("MTLO stall", 64'(bus.stall), 64'd0);
        @(posedge clk); #1;
        bus.valid = 1'b0;
        chk("MTLO lo", 64'(bus.lo), 64'h1234);
        chk("MTLO hi", 64'(bus.hi), 64'd5);

        // Asynchronous reset in the middle of a divide
        @(negedge clk);
        bus.valid = 1'b1; bus.funct = 6'b011010; bus.rs_val = 32'd100; bus.rt_val = 32'd7;
        repeat (5) @(posedge clk);
        #2;
        bus.valid = 1'b0; rst_n = 1'b0;
        #1;
        chk("rst mid-DIV stall", 64'(bus.stall), 64'd0);
        chk("rst mid-DIV hi", 64'(bus.hi), 64'd0);
        chk("rst mid-DIV lo", 64'(bus.lo), 64'd0);
        @(negedge clk); rst_n = 1'b1;

        // MULT immediately followed by MFHI
        run_md("MULT 1_0000*3_0000", 6'b011000, 32'h00010000, 32'h00030000, 32'd3, 32'd0);
        bus.alu_op = 3'b100; bus.funct = 6'b010000; bus.valid = 1'b1;
        #1;
        chk("MFHI code", 64'(bus.alu_control), 64'd8);
        chk("MFHI illegal", 64'(bus.illegal), 64'd0);
        chk("MFHI hi", 64'(bus.hi), 64'd3);
        chk("MFHI stall", 64'(bus.stall), 64'd0);
        bus.valid = 1'b0;
        @(posedge clk); #1;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
